uart_tx_arbiter: RTL

- Shares the single `uart` transmitter (9600 baud, 8 data bits, parity, 2 stop bits, clocked from clk50MHz) between NUM_REQ on-chip requesters.
- Grants ownership round-robin per message; a message is a burst of bytes ending at the byte flagged req_last.
- Sequences each byte into the UART with a start/busy handshake and returns a per-byte acknowledge to the owning requester.
- Sits between the requester clients (debug console, status reporter, etc.) and the `uart` tx datapath.

---
 rtl/uart_tx_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, per-message arbiter sharing one UART transmitter among NUM_REQ requesters
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST = 16
) (
  input  logic                          clk50MHz,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ack,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          uart_tx_start,
  output logic [DATA_WIDTH-1:0]         uart_tx_data,
  input  logic                          uart_tx_busy
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  typedef enum logic [1:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE} state_t;
  state_t state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d, ack_q, ack_d;
  logic start_q, start_d, last_q, last_d, found;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [BW-1:0] burst_q, burst_d;
  logic [IW-1:0] owner_q, owner_d, last_owner_q, last_owner_d, winner, idx;
  logic [2:0] tmo_q, tmo_d;
  assign req_ack = ack_q;
  assign grant = grant_q;
  assign uart_tx_start = start_q;
  assign uart_tx_data = data_q;
  always_comb begin
    winner = last_owner_q;
    found = 1'b0;
    idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IW'((int'(last_owner_q) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        winner = idx;
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ack_d = '0;
    start_d = 1'b0;
    data_d = data_q;
    burst_d = burst_q;
    owner_d = owner_q;
    last_owner_d = last_owner_q;
    last_d = last_q;
    tmo_d = '0;
    case (state_q)
      IDLE: begin
        if (found && !uart_tx_busy) begin
          owner_d = winner;
          grant_d = NUM_REQ'(1) << winner;
          burst_d = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (!req[owner_q]) begin
          grant_d = '0;
          last_owner_d = owner_q;
          state_d = IDLE;
        end else if (!uart_tx_busy) begin
          start_d = 1'b1;
          data_d = req_data[owner_q*DATA_WIDTH +: DATA_WIDTH];
          ack_d = grant_q;
          last_d = req_last[owner_q];
          burst_d = burst_q + 1'b1;
          state_d = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        tmo_d = tmo_q + 3'd1;
        state_d = (uart_tx_busy || tmo_q == 3'd7) ? WAIT_DONE : WAIT_BUSY;
      end
      WAIT_DONE: begin
        if (!uart_tx_busy) begin
          if (last_q || burst_q == BW'(MAX_BURST)) begin
            grant_d = '0;
            last_owner_d = owner_q;
            state_d = IDLE;
          end else begin
            state_d = SEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk50MHz) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      ack_q <= '0;
      start_q <= 1'b0;
      data_q <= '0;
      burst_q <= '0;
      owner_q <= '0;
      last_owner_q <= IW'(NUM_REQ - 1);
      last_q <= 1'b0;
      tmo_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ack_q <= ack_d;
      start_q <= start_d;
      data_q <= data_d;
      burst_q <= burst_d;
      owner_q <= owner_d;
      last_owner_q <= last_owner_d;
      last_q <= last_d;
      tmo_q <= tmo_d;
    end
  end
endmodule
